// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the register file and data memory.
// Steps one transfer at a time through DMAR/DMDR and the A bus, with a bounded memory wait.
//
// state | meaning
// IDLE  | ready for a command
// ADDR  | address register onto A bus, DMAR loads
// DATA  | store source register onto A bus, DMDR loads
// MEM   | memory request held until ack or wait limit
// WB    | DMDR onto A bus, destination register loads
// DONE  | transfer completed pulse
// ERR   | transfer aborted pulse
module mem_access_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [3:0]  cmd_addr_reg,
    input  logic [3:0]  cmd_data_reg,
    output logic [3:0]  a_sel,
    output logic        dmar_ld,
    output logic        dmdr_ld_bus,
    output logic        dmdr_ld_mem,
    output logic [11:0] reg_we,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_MEM, S_WB, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic       op_q, op_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] data_q, data_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            addr_q  <= 4'd0;
            data_q  <= 4'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        cmd_ready   = 1'b0;
        a_sel       = 4'd0;
        dmar_ld     = 1'b0;
        dmdr_ld_bus = 1'b0;
        dmdr_ld_mem = 1'b0;
        reg_we      = 12'd0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr_reg;
                    data_d = cmd_data_reg;
                    state_d = (cmd_addr_reg > 4'd11 || cmd_data_reg > 4'd11) ? S_ERR : S_ADDR;
                end
            end
            S_ADDR: begin
                a_sel   = 4'd3 + addr_q;
                dmar_ld = 1'b1;
                state_d = op_q ? S_DATA : S_MEM;
            end
            S_DATA: begin
                a_sel       = 4'd3 + data_q;
                dmdr_ld_bus = 1'b1;
                state_d     = S_MEM;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = op_q;
                // Only output fed by an input: read data is captured in the ack cycle itself.
                dmdr_ld_mem = mem_ack && !op_q;
                if (mem_ack) begin
                    cnt_d   = 8'd0;
                    state_d = op_q ? S_DONE : S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                a_sel   = 4'd2;
                reg_we  = 12'(1) << data_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a transfer-timeline model predicts every output cycle,
// and hand-computed completion cycles pin the model to the documented latencies.
module tb_mem_access_ctrl;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [3:0]  cmd_addr_reg = 4'd0;
    logic [3:0]  cmd_data_reg = 4'd0;
    logic [3:0]  a_sel;
    logic        dmar_ld, dmdr_ld_bus, dmdr_ld_mem;
    logic [11:0] reg_we;
    logic        mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic        done, err;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_reg(cmd_addr_reg), .cmd_data_reg(cmd_data_reg),
        .a_sel(a_sel), .dmar_ld(dmar_ld), .dmdr_ld_bus(dmdr_ld_bus),
        .dmdr_ld_mem(dmdr_ld_mem), .reg_we(reg_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .done(done), .err(err)
    );

    typedef struct packed {
        logic        rdy;
        logic [3:0]  asel;
        logic        dmar;
        logic        dbus;
        logic        dmem;
        logic [11:0] we;
        logic        req;
        logic        wem;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t expq[$];
    logic ackq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   req_cnt = 0;

    function automatic vec_t idle_vec();
        vec_t v;
        v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t dut_vec();
        vec_t v;
        v.rdy = cmd_ready; v.asel = a_sel; v.dmar = dmar_ld; v.dbus = dmdr_ld_bus;
        v.dmem = dmdr_ld_mem; v.we = reg_we; v.req = mem_req; v.wem = mem_we;
        v.dn = done; v.er = err;
        return v;
    endfunction

    task automatic check(input string nm, input vec_t e);
        vec_t g;
        g = dut_vec();
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got %h required %h", nm, $time, g, e);
        end
        n_vec++;
        if ($countones({dmar_ld, dmdr_ld_bus, dmdr_ld_mem, reg_we}) > 1 || a_sel == 4'hF) begin
            n_err++;
            $display("FAIL invariant @%0t: strobes %b a_sel %h required one-hot0 and a_sel!=F",
                     $time, {dmar_ld, dmdr_ld_bus, dmdr_ld_mem, reg_we}, a_sel);
        end
    endtask

    // Timeline of one transfer: acceptance cycle, then one entry per following cycle.
    // ack_at is the MEM cycle (1-based) that sees mem_ack, 0 for never; stray drives ack outside MEM.
    task automatic plan(input logic op, input logic [3:0] a, input logic [3:0] d,
                        input int ack_at, input logic stray);
        vec_t v;
        logic ak;
        expq.push_back(idle_vec()); ackq.push_back(stray);
        if (a > 11 || d > 11) begin
            v = '0; v.er = 1'b1; expq.push_back(v); ackq.push_back(stray);
            return;
        end
        v = '0; v.asel = 4'd3 + a; v.dmar = 1'b1; expq.push_back(v); ackq.push_back(stray);
        if (op) begin
            v = '0; v.asel = 4'd3 + d; v.dbus = 1'b1; expq.push_back(v); ackq.push_back(stray);
        end
        for (int i = 1; i <= WAIT_MAX; i++) begin
            ak = (i == ack_at);
            v = '0; v.req = 1'b1; v.wem = op; v.dmem = ak && !op;
            expq.push_back(v); ackq.push_back(ak);
            if (ak) begin
                if (!op) begin
                    v = '0; v.asel = 4'd2; v.we = 12'(1) << d;
                    expq.push_back(v); ackq.push_back(stray);
                end
                v = '0; v.dn = 1'b1; expq.push_back(v); ackq.push_back(stray);
                return;
            end
        end
        v = '0; v.er = 1'b1; expq.push_back(v); ackq.push_back(stray);
    endtask

    // Entered at posedge+1; drives ack, checks at negedge, returns at next posedge+1.
    task automatic cycle(output logic ev);
        vec_t e;
        e = idle_vec();
        mem_ack = 1'b0;
        if (expq.size() > 0) e = expq.pop_front();
        if (ackq.size() > 0) mem_ack = ackq.pop_front();
        @(negedge clk);
        check("cycle", e);
        ev = done | err;
        if (mem_req) req_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        logic ev;
        for (int i = 0; i < n; i++) cycle(ev);
    endtask

    task automatic issue(input string nm, input logic op, input logic [3:0] a, input logic [3:0] d,
                         input int ack_at, input logic stray, input logic hold, input int end_idx);
        logic ev;
        int   got;
        got = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr_reg = a; cmd_data_reg = d;
        plan(op, a, d, ack_at, stray);
        for (int i = 0; expq.size() > 0 && i < 64; i++) begin
            cycle(ev);
            if (ev && got < 0) got = i;
            if (i == 0) begin
                if (hold) begin
                    cmd_op = ~op; cmd_addr_reg = 4'hF; cmd_data_reg = 4'hF;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        n_vec++;
        if (got != end_idx) begin
            n_err++;
            $display("FAIL %s end cycle: got T+%0d required T+%0d", nm, got, end_idx);
        end
    endtask

    initial begin
        logic ev;
        #12;
        check("reset", idle_vec());
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        issue("load_imm", 1'b0, 4'd2, 4'd5, 1, 1'b0, 1'b0, 4);
        idle(1);
        issue("store_wait3", 1'b1, 4'd0, 4'd11, 4, 1'b0, 1'b0, 7);
        idle(1);

        req_cnt = 0;
        issue("load_timeout", 1'b0, 4'd3, 4'd6, 0, 1'b0, 1'b0, 17);
        n_vec++;
        if (req_cnt != WAIT_MAX) begin
            n_err++;
            $display("FAIL timeout_req_len: got %0d required %0d", req_cnt, WAIT_MAX);
        end
        idle(1);
        issue("store_ack_last", 1'b1, 4'd5, 4'd1, WAIT_MAX, 1'b0, 1'b0, 18);
        idle(1);

        issue("bad_data_idx", 1'b0, 4'd2, 4'd12, 1, 1'b0, 1'b0, 1);
        idle(1);
        issue("bad_addr_idx", 1'b1, 4'd13, 4'd4, 1, 1'b1, 1'b0, 1);
        idle(1);

        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr_reg = 4'd1; cmd_data_reg = 4'd3;
        plan(1'b0, 4'd1, 4'd3, 0, 1'b0);
        cycle(ev);
        cmd_valid = 1'b0;
        cycle(ev);
        cycle(ev);
        mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_mid_mem", idle_vec());
        expq.delete();
        ackq.delete();
        @(posedge clk); #1;
        check("reset_hold", idle_vec());
        rst_n = 1'b1;
        idle(1);
        issue("load_after_reset", 1'b0, 4'd4, 4'd7, 2, 1'b0, 1'b0, 5);
        idle(1);

        issue("b2b_first", 1'b0, 4'd7, 4'd9, 1, 1'b1, 1'b1, 4);
        issue("b2b_second", 1'b0, 4'd11, 4'd0, 2, 1'b1, 1'b0, 5);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
